quad_decoder: RTL and testbench

//   Quadrature front end for the up/down counter. It decodes raw A/B encoder pins into
//   the counter's en (one-cycle step pulse) and dir (1 = up, 0 = down) inputs.

---
 rtl/quad_decoder.sv | 103 ++++++++++
 tb/tb_quad_decoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchroniser, per-channel glitch filter, step/direction decode.
// Define QUAD_X4_EN to count every legal transition; by default only one count per encoder cycle.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic en,
  output logic dir,
  output logic err
);

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 5;
  localparam logic [CW-1:0] FLIM = CW'(FILTER_LEN);
  localparam logic [WW-1:0] WARM = WW'(FILTER_LEN + 2);

  // Bit 1 carries channel A, bit 0 channel B, so the 2-bit values read as {a,b}.
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [CW-1:0] fcnt [2];
  logic [WW-1:0] warm;

  logic          fwd_c;
  logic          rev_c;
  logic          dbl_c;
  logic          cnt_c;
  logic [1:0]    delta_c;

  // Position along the forward sequence 00->10->11->01->00.
  function automatic logic [1:0] pos(input logic [1:0] s);
    case (s)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
  endfunction

  always_comb begin
    delta_c = pos(filt) - pos(prev);
    fwd_c   = (delta_c == 2'd1);
    rev_c   = (delta_c == 2'd3);
    dbl_c   = (delta_c == 2'd2);
`ifdef QUAD_X4_EN
    cnt_c   = fwd_c | rev_c;
`else
    cnt_c   = (fwd_c && prev == 2'b01 && filt == 2'b00) ||
              (rev_c && prev == 2'b10 && filt == 2'b00);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 2'b00;
      s2   <= 2'b00;
      filt <= 2'b00;
      prev <= 2'b00;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      warm <= WARM;
      en   <= 1'b0;
      dir  <= 1'b1;
      err  <= 1'b0;
    end else begin
      s1  <= {a, b};
      s2  <= s1;
      en  <= 1'b0;
      err <= 1'b0;
      if (warm != '0) begin
        // Adopt whatever level the pins settled at, without reporting it as motion.
        warm <= warm - WW'(1);
        filt <= s2;
        prev <= s2;
        for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (s2[i] != filt[i]) begin
            if (fcnt[i] + CW'(1) == FLIM) begin
              filt[i] <= s2[i];
              fcnt[i] <= '0;
            end else begin
              fcnt[i] <= fcnt[i] + CW'(1);
            end
          end else begin
            fcnt[i] <= '0;
          end
        end
        prev <= filt;
        if (dbl_c) begin
          err <= 1'b1;
        end else if (fwd_c || rev_c) begin
          dir <= fwd_c;
          en  <= cnt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: step counts, direction, glitch rejection, error and reset warm-up.
module tb_quad_decoder;

`ifdef QUAD_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic en;
  logic dir;
  logic err;

  int total = 0;
  int bad   = 0;
  int en_n  = 0;
  int err_n = 0;
  logic [3:0] q = 4'd0;

  quad_decoder #(.FILTER_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .en  (en),
    .dir (dir),
    .err (err)
  );

  always #5 clk = ~clk;

  // Tally pulses and track a 4-bit up/down counter fed by en/dir.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_n = en_n + 1;
      q = (dir === 1'b1) ? q + 4'd1 : q - 4'd1;
    end
    if (err === 1'b1) err_n = err_n + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins(input logic [1:0] v, input int n);
    {a, b} = v;
    hold(n);
  endtask

  int e0;
  int r0;
  logic [1:0] fwd [4];
  logic [1:0] rev [4];

  initial begin
    fwd[0] = 2'b10; fwd[1] = 2'b11; fwd[2] = 2'b01; fwd[3] = 2'b00;
    rev[0] = 2'b01; rev[1] = 2'b11; rev[2] = 2'b10; rev[3] = 2'b00;

    // Reset state
    hold(3);
    check("rst_en", int'(en), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    hold(10);
    check("idle_en", en_n, 0);
    check("idle_err", err_n, 0);

    // Forward x4 cycles
    e0 = en_n; r0 = err_n;
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++) pins(fwd[s], 20);
    check("fwd_en_count", en_n - e0, X4 ? 16 : 4);
    check("fwd_err_count", err_n - r0, 0);
    check("fwd_dir", int'(dir), 1);
    check("fwd_counter", int'(q), X4 ? 0 : 4);

    // Reverse one cycle
    e0 = en_n; r0 = err_n;
    pins(rev[0], 20);
    check("rev_dir_first", int'(dir), 0);
    for (int s = 1; s < 4; s++) pins(rev[s], 20);
    check("rev_en_count", en_n - e0, X4 ? 4 : 1);
    check("rev_err_count", err_n - r0, 0);
    check("rev_counter", int'(q), X4 ? 12 : 3);

    // One-sample glitch on a is rejected
    e0 = en_n; r0 = err_n;
    a = 1'b1;
    @(negedge clk);
    a = 1'b0;
    hold(20);
    check("glitch_en", en_n - e0, 0);
    check("glitch_err", err_n - r0, 0);
    check("glitch_dir", int'(dir), 0);

    // Two-sample pulse on a: rise decodes at N+4, fall at N+6
    a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("pulse_en_k%0d", k), int'(en), ((k == 6) || (X4 && k == 4)) ? 1 : 0);
      check($sformatf("pulse_dir_k%0d", k), int'(dir), (k == 4 || k == 5) ? 1 : 0);
      if (k == 1) a = 1'b0;
    end
    hold(20);

    // Both channels change together
    e0 = en_n; r0 = err_n;
    pins(2'b11, 20);
    check("dbl_err_count", err_n - r0, 1);
    check("dbl_en_count", en_n - e0, 0);
    check("dbl_dir", int'(dir), 0);
    e0 = en_n;
    pins(2'b01, 20);
    check("after_dbl_en", en_n - e0, X4 ? 1 : 0);
    check("after_dbl_dir", int'(dir), 1);
    e0 = en_n;
    pins(2'b00, 20);
    check("after_dbl_en2", en_n - e0, 1);

    // Reset with pins at 11: nothing reported for the held level
    e0 = en_n; r0 = err_n;
    {a, b} = 2'b11;
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(25);
    check("warm_en", en_n - e0, 0);
    check("warm_err", err_n - r0, 0);
    check("warm_dir", int'(dir), 1);
    e0 = en_n;
    pins(2'b01, 20);
    check("warm_step1_en", en_n - e0, X4 ? 1 : 0);
    e0 = en_n;
    pins(2'b00, 20);
    check("warm_step2_en", en_n - e0, 1);
    check("warm_err_end", err_n - r0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
